// File: rtl/avmm_triple_arbiter.sv
// avmm_triple_arbiter: round-robin Avalon-MM master sharing one multiply-by-3 slave among NREQ requesters
module avmm_triple_arbiter #(
    parameter int N     = 32,
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic              csi_clk,
    input  logic              rsi_reset_n,
    output logic [7:0]        avm_m0_address,
    output logic              avm_m0_write,
    output logic [N-1:0]      avm_m0_writedata,
    output logic              avm_m0_read,
    input  logic [N-1:0]      avm_m0_readdata,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_data,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] rr_last, gnt, gnt_nxt, idx;
    logic          found;
    logic [N-1:0]  op;

    assign avm_m0_address   = '0;
    assign avm_m0_write     = state == WR;
    assign avm_m0_read      = state == RD;
    assign avm_m0_writedata = op;
    assign busy             = state != IDLE;

    // round-robin search starting after rr_last; descending loop so the nearest candidate wins
    always_comb begin
        gnt_nxt = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(rr_last) + k) % NREQ);
            if (req_valid[idx]) begin
                found   = 1'b1;
                gnt_nxt = idx;
            end
        end
    end

    // next-state and combinational accept strobe
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        unique case (state)
            IDLE: if (found) begin
                state_nxt = WR;
                req_ready = NREQ'(1) << gnt_nxt;
            end
            WR:      state_nxt = RD;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register, operand capture on grant, result capture and counting on CAP
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state     <= IDLE;
            rr_last   <= IW'(NREQ - 1);
            gnt       <= '0;
            op        <= '0;
            rsp_data  <= '0;
            rsp_valid <= '0;
            ops_done  <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= '0;
            if (state == IDLE && found) begin
                op      <= req_data[gnt_nxt*N +: N];
                gnt     <= gnt_nxt;
                rr_last <= gnt_nxt;
            end
            if (state == CAP) begin
                rsp_data  <= avm_m0_readdata;
                rsp_valid <= NREQ'(1) << gnt;
                ops_done  <= ops_done + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_avmm_triple_arbiter.sv
// tb_avmm_triple_arbiter: scoreboard bench for the round-robin triple arbiter with a behavioural x3 slave
module tb_avmm_triple_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  avm_m0_address;
    logic        avm_m0_write;
    logic [31:0] avm_m0_writedata;
    logic        avm_m0_read;
    logic [31:0] avm_m0_readdata = '0;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic [15:0] ops_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [31:0] slave_mem = '0;
    logic [31:0] exp_wr[$];
    logic [33:0] exp_rsp[$];

    avmm_triple_arbiter #(.N(32), .NREQ(2), .CNT_W(16)) dut (
        .csi_clk(clk), .rsi_reset_n(rst_n),
        .avm_m0_address(avm_m0_address), .avm_m0_write(avm_m0_write),
        .avm_m0_writedata(avm_m0_writedata), .avm_m0_read(avm_m0_read),
        .avm_m0_readdata(avm_m0_readdata),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // behavioural slave: stores 3*operand on write, registered readdata on read
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_m0_write) slave_mem <= avm_m0_writedata * 32'd3;
        if (avm_m0_read) avm_m0_readdata <= slave_mem;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_grant(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("grant_req%0d_seen", i), 64'(ok), 64'd1);
    endtask

    // monitor: pops scoreboard entries whenever the DUT shows a write or a response
    always @(negedge clk) begin
        if (rst_n) begin
            if (avm_m0_write && avm_m0_read) chk("strobe_overlap", 64'd1, 64'd0);
            if (avm_m0_write) begin
                chk("wr_address", 64'(avm_m0_address), 64'd0);
                if (exp_wr.size() == 0) chk("unexpected_write", 64'(avm_m0_writedata), 64'hdead);
                else chk("writedata", 64'(avm_m0_writedata), 64'(exp_wr.pop_front()));
            end
            if (rsp_valid != 2'b00) begin
                if (exp_rsp.size() == 0) chk("unexpected_rsp", {30'd0, rsp_valid, rsp_data}, 64'hdead);
                else chk("rsp", {30'd0, rsp_valid, rsp_data}, 64'(exp_rsp.pop_front()));
            end
        end
    end

    initial begin
        bit ok;
        int gcyc[4];
        int bad;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {req_ready, rsp_valid, avm_m0_write, avm_m0_read, busy, ops_done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // requester 0 alone, exact latency
        req_data[31:0] = 32'd5; req_valid = 2'b01;
        exp_wr.push_back(32'd5); exp_rsp.push_back({2'b01, 32'd15});
        wait_grant(0, ok);
        @(posedge clk); #1; req_valid = 2'b00;
        @(negedge clk); chk("t1_write", {avm_m0_write, avm_m0_read, busy}, 3'b101);
        @(negedge clk); chk("t2_read", {avm_m0_write, avm_m0_read}, 2'b01);
        @(negedge clk); chk("t3_no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk); chk("t4_rsp", {rsp_valid, rsp_data, ops_done}, {2'b01, 32'd15, 16'd1});

        // requester 1 alone, product wraps mod 2^32
        @(posedge clk); #1;
        req_data[63:32] = 32'h6000_0000; req_valid = 2'b10;
        exp_wr.push_back(32'h6000_0000); exp_rsp.push_back({2'b10, 32'h2000_0000});
        wait_grant(1, ok);
        @(posedge clk); #1; req_valid = 2'b00;
        repeat (5) @(negedge clk);
        chk("ops_after_two", 64'(ops_done), 64'd2);
        chk("rsp_data_hold", 64'(rsp_data), 64'h2000_0000);

        // both requesters held valid after reset: grants alternate every 4 cycles
        rst_n = 1'b0; #3; rst_n = 1'b1;
        @(posedge clk); #1;
        req_data = {32'd2, 32'd1}; req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_wr.push_back(g % 2 ? 32'd2 : 32'd1);
            exp_rsp.push_back(g % 2 ? {2'b10, 32'd6} : {2'b01, 32'd3});
        end
        for (int g = 0; g < 4; g++) begin
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (req_ready != 2'b00) begin ok = 1'b1; break; end
            end
            chk($sformatf("rr_grant%0d", g), {63'd0, ok} << 2 | 64'(req_ready), g % 2 ? 64'd6 : 64'd5);
            gcyc[g] = cyc;
            if (g > 0) chk($sformatf("rr_spacing%0d", g), 64'(gcyc[g] - gcyc[g-1]), 64'd4);
        end
        @(posedge clk); #1; req_valid = 2'b00;
        repeat (6) @(negedge clk);
        chk("ops_after_rr", 64'(ops_done), 64'd4);

        // idle: no bus or handshake activity for 20 cycles
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (avm_m0_write || avm_m0_read || req_ready != 0 || rsp_valid != 0 || busy) bad++;
        end
        chk("idle_quiet_cycles", 64'(bad), 64'd0);

        // reset during RD of a requester 1 operation
        @(posedge clk); #1;
        req_data[63:32] = 32'd8; req_valid = 2'b10;
        exp_wr.push_back(32'd8);
        wait_grant(1, ok);
        @(posedge clk); #1; req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("in_rd_before_reset", 64'(avm_m0_read), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {avm_m0_read, avm_m0_write, busy, rsp_valid, ops_done, avm_m0_writedata}, 64'd0);
        req_data = {32'd8, 32'd7}; req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rsp_after_reset", 64'(rsp_valid), 64'd0);
        exp_wr.push_back(32'd7); exp_rsp.push_back({2'b01, 32'd21});
        @(negedge clk);
        chk("first_grant_after_reset", 64'(req_ready), 64'd1);
        @(posedge clk); #1; req_valid = 2'b00;
        repeat (5) @(negedge clk);

        // operand changes during WR must not affect the operation in flight
        @(posedge clk); #1;
        req_data[31:0] = 32'd5; req_valid = 2'b01;
        exp_wr.push_back(32'd5); exp_rsp.push_back({2'b01, 32'd15});
        wait_grant(0, ok);
        @(posedge clk); #1; req_data[31:0] = 32'd9; req_valid = 2'b00;
        @(negedge clk); chk("wr_hold_operand", 64'(avm_m0_writedata), 64'd5);
        repeat (5) @(negedge clk);
        chk("rsp_data_after_change", 64'(rsp_data), 64'd15);
        chk("ops_final", 64'(ops_done), 64'd2);

        for (int k = 0; k < 20 && (exp_wr.size() != 0 || exp_rsp.size() != 0); k++) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_wr.size() + exp_rsp.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/avmm_triple_arbiter.md
Name: avmm_triple_arbiter

Overview:
- Avalon-MM master that shares the single "multiply by 3" Avalon-MM slave among NREQ local requesters.
- Each requester hands over an operand through a valid/ready handshake.
- The block arbitrates round-robin, writes the operand to slave address 0, reads address 0 back, and returns the result to the granted requester as a one-cycle response pulse.
- Sits between compute clients and the slave on the same clock domain.

Parameters:
- N, 32, operand/result width; matches the slave data width.
- NREQ, 2, number of requesters (>=2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- csi_clk  input  1  system clock, all logic on posedge.
- rsi_reset_n  input  1  asynchronous, active-low reset.
- avm_m0_address  output  8  slave address; always 0 during an access.
- avm_m0_write  output  1  slave write strobe.
- avm_m0_writedata  output  N  operand to slave.
- avm_m0_read  output  1  slave read strobe.
- avm_m0_readdata  input  N  slave result, registered by the slave (valid the cycle after read).
- req_valid  input  NREQ  per-requester operand valid.
- req_data  input  NREQ*N  flattened operands; requester i occupies bits [i*N +: N].
- req_ready  output  NREQ  one-hot accept strobe.
- rsp_valid  output  NREQ  one-hot result strobe, one cycle.
- rsp_data  output  N  result; shared by all requesters.
- busy  output  1  high when the state is not IDLE.
- ops_done  output  CNT_W  count of completed operations; wraps.

Behaviour:
- Clock and reset: one clock, csi_clk. Reset rsi_reset_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, rr_last=NREQ-1 (requester 0 has first priority).
  - avm_m0_write=0, avm_m0_read=0, avm_m0_address=0, avm_m0_writedata=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, ops_done=0, busy=0.
- State machine: IDLE -> WR -> RD -> CAP -> IDLE.
  - IDLE:
    - If any req_valid, grant g = first set bit searching from rr_last+1 upward, wrapping.
    - req_ready[g]=1 combinationally this cycle only.
    - On the edge: op<=req_data[g], gnt<=g, rr_last<=g, go WR.
    - If no req_valid: stay in IDLE with no bus activity.
  - WR: avm_m0_write=1, address 0, writedata=op; one cycle, then RD.
  - RD: avm_m0_read=1, address 0; one cycle, then CAP.
  - CAP: sample avm_m0_readdata. On the edge: rsp_data<=readdata, rsp_valid<=onehot(gnt), ops_done<=ops_done+1, go IDLE.
- Strobe decoding: avm strobes and address are decoded from the state register, so only one strobe is high at a time. Write and read are never asserted together.
- Latency and throughput:
  - Acceptance at cycle t -> write at t+1 -> read at t+2 -> readdata sampled at t+3 -> rsp_valid at t+4.
  - A new grant may occur in the same IDLE cycle as rsp_valid, giving one operation per 4 cycles sustained.
- rsp_valid is a one-cycle pulse. rsp_data holds its value until the next capture.
- Arithmetic: the result passes through unchanged from the slave (3*A mod 2^N). No overflow flag.
- Handshake rules:
  - A requester holds req_valid and req_data until it sees req_ready.
  - Dropping req_valid before a grant is legal and has no effect.
  - req_data is sampled only in the grant cycle; later changes do not affect the operation in flight.
- Simultaneous requests: exactly one grant per IDLE cycle. Fairness: no requester waits more than NREQ-1 other operations.
- A request arriving while busy is not accepted until the next IDLE.
- ops_done wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: the FSM returns to IDLE immediately and all outputs take their reset values. The in-flight operation is discarded with no rsp_valid. The requester must resubmit.

Test Plan:
- N=32, NREQ=2. Requester 0 alone with data=5, granted at t -> avm_m0_write with writedata=5 at t+1; avm_m0_read at t+2; rsp_valid=2'b01, rsp_data=15 at t+4; ops_done=1.
- Requester 1 alone with data=0x6000_0000 -> rsp_valid=2'b10, rsp_data=0x2000_0000 (wrap mod 2^32).
- Both requesters held valid, data0=1 and data1=2, after reset -> grant order 0,1,0,1. Responses 3 (01), 6 (10), 3, 6, spaced 4 cycles apart; ops_done=4.
- No requests for 20 cycles -> write, read, req_ready and rsp_valid stay 0; busy=0.
- Reset asserted during RD of a requester 1 operation -> outputs 0 asynchronously, no rsp_valid. After release with both requesters valid, requester 0 is granted first.
- req_data changed during WR (5 -> 9) -> writedata stays 5 and rsp_data=15.
